// File: rtl/down_counter_timer.sv
// down_counter_timer
//
// Loadable programmable down counter for interval timing and event division.
// A start value is loaded, the count then drops by one on every enabled clock,
// and a one-cycle terminal-count pulse marks the edge on which q reaches 0.
// In periodic mode the next enabled edge after terminal count reloads the
// last loaded value. In one-shot mode that edge stops the counter.
//
// Ports:
//   clk       system clock; all state changes on the rising edge
//   rst       asynchronous reset, active low
//   en        count enable; decrement and reload happen only when en=1
//   load      synchronous load strobe; wins over en in every state
//   load_val  start value captured on load
//   mode      0 = one-shot, 1 = periodic; sampled at each terminal decision
//   q         current count (registered)
//   tc        terminal-count pulse (registered), one cycle wide
//   busy      high while the counter is running or sitting at terminal count
//   state_dbg current FSM state encoding, for observation only
module down_counter_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             mode,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ZERO = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] reload;

  // busy comes straight from the state register, so it changes on the same
  // edge as the state and drops asynchronously with reset.
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q      <= '0;
      reload <= '0;
      tc     <= 1'b0;
      state  <= IDLE;
    end else if (load) begin
      // A zero load never enters RUN, so reload is nonzero whenever the
      // counter is in RUN or ZERO.
      q      <= load_val;
      reload <= load_val;
      tc     <= 1'b0;
      state  <= (load_val != '0) ? RUN : IDLE;
    end else begin
      // tc defaults low every edge so it is a single-cycle pulse even when
      // en stays low while sitting in ZERO.
      tc <= 1'b0;
      if (en) begin
        case (state)
          RUN: begin
            if (q == WIDTH'(1)) begin
              q     <= '0;
              tc    <= 1'b1;
              state <= ZERO;
            end else begin
              q <= q - WIDTH'(1);
            end
          end
          ZERO: begin
            if (mode) begin
              q     <= reload;
              state <= RUN;
            end else begin
              state <= IDLE;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_down_counter_timer.sv
// Self-checking bench for down_counter_timer (WIDTH=4).
module tb_down_counter_timer;

  localparam int W = 4;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         load;
  logic [W-1:0] load_val;
  logic         mode;
  logic [W-1:0] q;
  logic         tc;
  logic         busy;
  logic [1:0]   state_dbg;

  always #5 clk = ~clk;

  down_counter_timer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .load      (load),
    .load_val  (load_val),
    .mode      (mode),
    .q         (q),
    .tc        (tc),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  int checks   = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  // The timer is described as: a count value, the value it restarts from,
  // and whether it is "armed". An armed timer that already shows 0 has
  // expired; its next enabled edge either restarts it or disarms it.
  logic [W-1:0] m_q;
  logic [W-1:0] m_reload;
  bit           m_armed;
  bit           m_tc;

  task automatic model_reset();
    m_q      = '0;
    m_reload = '0;
    m_armed  = 0;
    m_tc     = 0;
  endtask

  task automatic model_edge(input bit ld, input logic [W-1:0] lv,
                            input bit e, input bit md);
    m_tc = 0;
    if (ld) begin
      m_q      = lv;
      m_reload = lv;
      m_armed  = (lv != 0);
    end else if (e && m_armed) begin
      if (m_q == 0) begin
        if (md) m_q = m_reload;
        else    m_armed = 0;
      end else begin
        m_q  = m_q - 1;
        m_tc = (m_q == 0);
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int cyc         = 0;
  int tc_count    = 0;
  int last_tc_cyc = 0;
  int tc_period   = 0;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check_val({tag, "_q"},    {{(32-W){1'b0}}, q}, {{(32-W){1'b0}}, m_q});
    check_val({tag, "_tc"},   {31'b0, tc},         {31'b0, m_tc});
    check_val({tag, "_busy"}, {31'b0, busy},       {31'b0, m_armed});
  endtask

  // ---------------- driver tasks ----------------
  // Drive inputs 1 time unit after a rising edge, clock once, sample 1 unit
  // after that edge.
  task automatic step(input bit ld, input logic [W-1:0] lv, input bit e,
                      input bit md, input string tag);
    load     = ld;
    load_val = lv;
    en       = e;
    mode     = md;
    @(posedge clk);
    model_edge(ld, lv, e, md);
    cyc++;
    #1;
    if (tc === 1'b1) begin
      tc_period   = cyc - last_tc_cyc;
      last_tc_cyc = cyc;
      tc_count++;
    end
    check_model(tag);
  endtask

  task automatic reset_cycle(input string tag);
    @(posedge clk);
    cyc++;
    #1;
    check_model(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset held with a load request present.
    rst = 1'b0; load = 1'b1; load_val = 4'd9; en = 1'b1; mode = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) reset_cycle("reset_hold");
    rst = 1'b1; load = 1'b0; en = 1'b0;
    step(0, 0, 0, 0, "post_reset");
    step(0, 0, 1, 0, "post_reset_en");

    // One-shot 5: 5,4,3,2,1,0 then idle.
    step(1, 5, 1, 0, "os_load");
    check_val("os_load_q", {28'b0, q}, 32'd5);
    exp_q = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
    while (exp_q.size() > 0) begin
      logic [W-1:0] e_q;
      e_q = exp_q.pop_front();
      step(0, 0, 1, 0, "os_run");
      check_val("os_seq_q", {28'b0, q}, {28'b0, e_q});
      check_val("os_seq_tc", {31'b0, tc}, {31'b0, (e_q == 0)});
    end
    for (int i = 0; i < 11; i++) begin
      step(0, 0, 1, 0, "os_idle");
      check_val("os_idle_busy", {31'b0, busy}, 32'd0);
    end

    // Periodic 3: tc every 4 enabled edges, busy stays high.
    step(1, 3, 1, 1, "per_load");
    tc_count = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 1, 1, "per_run");
      check_val("per_busy", {31'b0, busy}, 32'd1);
    end
    check_val("per_tc_count", tc_count, 2);
    check_val("per_tc_period", tc_period, 4);

    // Enable gating, then en frozen low while at terminal count.
    step(1, 4, 1, 0, "gate_load");
    tc_count = 0;
    for (int i = 0; i < 8; i++) step(0, 0, (i % 2) == 0, 0, "gate_toggle");
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, "gate_freeze");
      check_val("gate_freeze_q", {28'b0, q}, 32'd0);
    end
    check_val("gate_tc_count", tc_count, 1);
    step(0, 0, 1, 0, "gate_stop");

    // Load 0 goes straight to idle.
    step(1, 0, 1, 1, "zero_load");
    check_val("zero_load_busy", {31'b0, busy}, 32'd0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, "zero_idle");

    // Maximum periodic load: period 16.
    step(1, 15, 1, 1, "max_load");
    tc_count = 0;
    for (int i = 0; i < 40; i++) step(0, 0, 1, 1, "max_run");
    check_val("max_tc_count", tc_count, 2);
    check_val("max_tc_period", tc_period, 16);

    // Load during terminal count replaces the pending reload.
    step(1, 3, 1, 1, "zl_load");
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, "zl_run");
    check_val("zl_at_zero_tc", {31'b0, tc}, 32'd1);
    step(1, 2, 1, 1, "zl_reload");
    check_val("zl_reload_q", {28'b0, q}, 32'd2);
    step(0, 0, 1, 1, "zl_after");

    // Asynchronous reset between edges.
    step(1, 7, 1, 0, "ar_load");
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, "ar_run");
    check_val("ar_before_q", {28'b0, q}, 32'd4);
    #2 rst = 1'b0;
    model_reset();
    #1;
    check_val("ar_async_q", {28'b0, q}, 32'd0);
    check_val("ar_async_busy", {31'b0, busy}, 32'd0);
    check_val("ar_async_tc", {31'b0, tc}, 32'd0);
    #2 rst = 1'b1;
    tc_count = 0;
    for (int i = 0; i < 6; i++) step(0, 0, 1, 0, "ar_after");
    check_val("ar_no_tc", tc_count, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      bit           r_ld;
      logic [W-1:0] r_lv;
      r_ld = ($urandom_range(0, 9) == 0);
      r_lv = W'($urandom_range(0, (1 << W) - 1));
      step(r_ld, r_lv, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/down_counter_timer.md
Name: down_counter_timer

Overview:
- Loadable, programmable down counter: the count-down counterpart to the existing up-counting RippleCarryCounter.
- Used as an interval timer or event divider. Software or the surrounding logic loads a start value; the block decrements once per enabled clock and flags terminal count.
- Supports one-shot and periodic (auto-reload) modes.
- Fully synchronous to one clock, with an asynchronous active-low reset.

Parameters:
- WIDTH, 4, counter and load-value width in bits (legal range 2..32).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous reset, active-low. rst=0 immediately forces the reset state.
- en  input  1  count enable. Decrement/reload only occurs on edges where en=1.
- load  input  1  synchronous load strobe; highest priority after reset.
- load_val  input  WIDTH  start value captured on load.
- mode  input  1  0 = one-shot, 1 = periodic. Sampled every cycle, not latched.
- q  output  WIDTH  current count (registered).
- tc  output  1  terminal-count pulse (registered), high exactly one cycle.
- busy  output  1  high while the FSM is in RUN or ZERO.

Behaviour:
- Reset (rst=0, asynchronous):
  - Outputs: q=0, tc=0, busy=0.
  - Internal state: reload register=0, FSM=IDLE.
  - Recovery: on rst deassertion, nothing changes until the next rising clk.
- FSM states: IDLE, RUN, ZERO.
- Priority per edge: load > en-driven update > hold.
- load=1, in any state, regardless of en:
  - q<=load_val; reload<=load_val; tc<=0.
  - Next state is RUN if load_val!=0, otherwise IDLE (tc is not asserted).
  - A load during ZERO aborts the pending reload or stop.
- IDLE:
  - q holds; busy=0; tc=0.
  - en has no effect.
- RUN, en=1, q>1: q<=q-1.
- RUN, en=1, q==1: q<=0; tc<=1; next state ZERO.
- ZERO, en=1:
  - mode=1: q<=reload; next state RUN (RUN is valid because reload is always nonzero here); tc<=0.
  - mode=0: q stays 0; next state IDLE; busy<=0; tc<=0.
- en=0 (RUN or ZERO): q and state hold; tc<=0. tc is a single-cycle pulse even if en stays low.
- Timing:
  - Load value N gives tc asserted N enabled edges after load, coincident with q==0.
  - Periodic mode: tc recurs every N+1 enabled edges.
- Arithmetic: unsigned, WIDTH bits.
  - Underflow never occurs; the q==0 path is handled by the ZERO state.
  - load_val = 2^WIDTH-1 is legal; it gives the maximum period.
- busy is combinationally derived from the state register (no extra latency) and is 1 in RUN and ZERO.
- Mode change mid-count takes effect at the next ZERO decision.
- Reset mid-count aborts immediately, including a tc pulse in flight.

Test Plan:
- Reset: hold rst=0 for 3 cycles with load=1, load_val=9 → q=0, tc=0, busy=0 throughout; after release with no load → q remains 0, busy=0.
- One-shot: WIDTH=4, mode=0, load 5, en=1 constant → q sequence 5,4,3,2,1,0 with tc=1 only on the q=0 cycle; next cycle busy=0, q=0 held for 10 further cycles.
- Periodic: mode=1, load 3, en=1 → q 3,2,1,0,3,2,1,0,...; tc high every 4th cycle; busy stays 1.
- Enable gating: load 4, toggle en 1,0,1,0,... → q decrements only on en=1 edges; freezing en=0 during ZERO keeps q=0 with tc high for one cycle only.
- Boundaries:
  - load 0 → IDLE, no tc, busy=0.
  - load 15 (max) periodic → tc period 16 cycles.
  - load 2 asserted on the ZERO cycle → q=2, no reload to the old value.
- Async reset mid-run: load 7, count to 4, pulse rst low between clock edges → q=0, busy=0 immediately (before the next edge); no tc afterward.
